// File: rtl/umi_ram.sv
// Single-port UMI RAM device: services read, write and posted-write
// requests against a byte-addressable word memory with one response stage.
module umi_ram #(
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam logic [4:0] REQ_POSTED = 5'h05;

  logic [DW-1:0] mem [DEPTH];

  logic [4:0]    op;
  logic [2:0]    size;
  logic [7:0]    len;
  logic [16:0]   lenp1;
  logic [16:0]   nbytes;
  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic          accept;
  logic          is_rd;
  logic          is_wr;
  logic          is_pw;
  logic [NB-1:0] wmask;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rword;
  logic [DW-1:0] rsh;
  logic [DW-1:0] rdata;

  assign op     = udev_req_cmd[4:0];
  assign size   = udev_req_cmd[7:5];
  assign len    = udev_req_cmd[15:8];
  assign lenp1  = {9'd0, len} + 17'd1;
  assign nbytes = lenp1 << size;
  assign off    = udev_req_dstaddr[OW-1:0];
  assign idx    = udev_req_dstaddr[OW +: IW];

  assign udev_req_ready = !udev_resp_valid | udev_resp_ready;
  assign accept = udev_req_valid & udev_req_ready;

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    is_pw = 1'b0;
    unique case (1'b1)
      (op == REQ_READ):   is_rd = 1'b1;
      (op == REQ_WRITE):  is_wr = 1'b1;
      (op == REQ_POSTED): is_pw = 1'b1;
      default: ;
    endcase
  end

  // Bytes beyond the end of the addressed word are dropped, never wrapped.
  always_comb begin
    wdata = udev_req_data << {off, 3'b000};
    wmask = '0;
    for (int j = 0; j < NB; j++) begin
      wmask[j] = (j >= int'(off)) &&
                 ((j - int'(off)) < int'(nbytes));
    end
  end

  always_comb begin
    rword = mem[idx];
    rsh   = rword >> {off, 3'b000};
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes)) rdata[8*i +: 8] = rsh[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (is_wr || is_pw)) begin
      for (int j = 0; j < NB; j++) begin
        if (wmask[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      udev_resp_valid   <= 1'b0;
      udev_resp_cmd     <= '0;
      udev_resp_dstaddr <= '0;
      udev_resp_srcaddr <= '0;
      udev_resp_data    <= '0;
    end else if (accept && (is_rd || is_wr)) begin
      udev_resp_valid   <= 1'b1;
      udev_resp_cmd     <= {udev_req_cmd[CW-1:5],
                            is_rd ? RESP_READ : RESP_WRITE};
      udev_resp_dstaddr <= udev_req_srcaddr;
      udev_resp_srcaddr <= udev_req_dstaddr;
      udev_resp_data    <= is_rd ? rdata : '0;
    end else if (udev_resp_ready) begin
      udev_resp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_umi_ram.sv
// Directed bench for umi_ram: write/read, posted and offset access,
// backpressure, throughput, illegal opcode and reset mid-transaction.
module tb_umi_ram;

  logic         clk;
  logic         nreset;
  logic         req_valid;
  logic [31:0]  req_cmd;
  logic [63:0]  req_dst;
  logic [63:0]  req_src;
  logic [255:0] req_data;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_cmd;
  logic [63:0]  resp_dst;
  logic [63:0]  resp_src;
  logic [255:0] resp_data;
  logic         resp_ready;

  int nvec;
  int nmis;
  int nresp;
  logic [255:0] qd[$];
  logic [31:0]  qc[$];

  umi_ram dut (
    .clk               (clk),
    .nreset            (nreset),
    .udev_req_valid    (req_valid),
    .udev_req_cmd      (req_cmd),
    .udev_req_dstaddr  (req_dst),
    .udev_req_srcaddr  (req_src),
    .udev_req_data     (req_data),
    .udev_req_ready    (req_ready),
    .udev_resp_valid   (resp_valid),
    .udev_resp_cmd     (resp_cmd),
    .udev_resp_dstaddr (resp_dst),
    .udev_resp_srcaddr (resp_src),
    .udev_resp_data    (resp_data),
    .udev_resp_ready   (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (nreset && resp_valid && resp_ready) begin
      nresp++;
      qd.push_back(resp_data);
      qc.push_back(resp_cmd);
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] op,
                                     input logic [2:0] sz,
                                     input logic [7:0] ln);
    return {16'h0, ln, sz, op};
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] sz,
                       input logic [7:0] ln, input logic [63:0] dst,
                       input logic [63:0] src, input logic [255:0] d);
    req_valid = 1'b1;
    req_cmd   = mk(op, sz, ln);
    req_dst   = dst;
    req_src   = src;
    req_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  int n0;
  logic [255:0] e;

  initial begin
    nvec = 0;
    nmis = 0;
    nresp = 0;
    nreset = 1'b0;
    req_valid = 1'b0;
    req_cmd = '0;
    req_dst = '0;
    req_src = '0;
    req_data = '0;
    resp_ready = 1'b1;

    // Reset state
    cyc(2);
    chk("rst_valid", 256'(resp_valid), 256'd0);
    chk("rst_ready", 256'(req_ready), 256'd1);
    chk("rst_cmd", 256'(resp_cmd), 256'd0);
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("idle_valid", 256'(resp_valid), 256'd0);
    end

    // Write then read back-to-back
    issue(5'h03, 3'd3, 8'd0, 64'h100, 64'hA0,
          256'h1122334455667788);
    chk("wr_valid", 256'(resp_valid), 256'd1);
    chk("wr_cmd", 256'(resp_cmd), 256'(mk(5'h04, 3'd3, 8'd0)));
    chk("wr_dst", 256'(resp_dst), 256'hA0);
    chk("wr_src", 256'(resp_src), 256'h100);
    chk("wr_data", resp_data, 256'd0);
    issue(5'h01, 3'd3, 8'd0, 64'h100, 64'hA0, 256'd0);
    chk("rd_valid", 256'(resp_valid), 256'd1);
    chk("rd_cmd", 256'(resp_cmd), 256'(mk(5'h02, 3'd3, 8'd0)));
    chk("rd_data", resp_data, 256'h1122334455667788);
    cyc(1);
    chk("rd_drain", 256'(resp_valid), 256'd0);

    // Posted write at a byte offset
    issue(5'h03, 3'd3, 8'd0, 64'h200, 64'hA4,
          256'h0102030405060708);
    cyc(1);
    issue(5'h05, 3'd0, 8'd3, 64'h203, 64'hA8, 256'hDEADBEEF);
    chk("pw_noresp", 256'(resp_valid), 256'd0);
    issue(5'h01, 3'd3, 8'd0, 64'h200, 64'hAC, 256'd0);
    chk("pw_rd", resp_data, 256'h01DEADBEEF060708);

    // Write near the end of a word: bytes past the word end are dropped
    issue(5'h03, 3'd3, 8'd0, 64'h21C, 64'hAC,
          256'h8877665544332211);
    issue(5'h01, 3'd3, 8'd0, 64'h21C, 64'hAC, 256'd0);
    chk("edge_rd", resp_data, 256'h44332211);
    cyc(1);

    // Backpressure with a request held waiting
    resp_ready = 1'b0;
    issue(5'h01, 3'd3, 8'd0, 64'h200, 64'hB4, 256'd0);
    n0 = nresp;
    req_valid = 1'b1;
    req_cmd   = mk(5'h03, 3'd3, 8'd0);
    req_dst   = 64'h300;
    req_src   = 64'hB0;
    req_data  = 256'hCAFE;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", 256'(req_ready), 256'd0);
      chk("bp_data", resp_data, 256'h01DEADBEEF060708);
      chk("bp_dst", 256'(resp_dst), 256'hB4);
      cyc(1);
    end
    chk("bp_valid", 256'(resp_valid), 256'd1);
    resp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 256'(req_ready), 256'd1);
    cyc(1);
    req_valid = 1'b0;
    chk("bp_one", 256'(nresp - n0), 256'd1);
    chk("bp_wr_dst", 256'(resp_dst), 256'hB0);
    chk("bp_wr_cmd", 256'(resp_cmd), 256'(mk(5'h04, 3'd3, 8'd0)));
    cyc(1);
    chk("bp_two", 256'(nresp - n0), 256'd2);
    chk("bp_drain", 256'(resp_valid), 256'd0);

    // Throughput: 16 writes then 16 reads, back-to-back
    n0 = nresp;
    qd.delete();
    qc.delete();
    for (int k = 0; k < 16; k++) begin
      chk("tp_wr_ready", 256'(req_ready), 256'd1);
      issue(5'h03, 3'd3, 8'd0, 64'(32 * k), 64'h40 + 64'(k),
            {192'd0, 32'(k), 32'hA5A50000 + 32'(k)});
    end
    for (int k = 0; k < 16; k++) begin
      chk("tp_rd_ready", 256'(req_ready), 256'd1);
      issue(5'h01, 3'd3, 8'd0, 64'(32 * k), 64'h60 + 64'(k), 256'd0);
    end
    cyc(1);
    chk("tp_count", 256'(nresp - n0), 256'd32);
    for (int i = 0; i < 16; i++)
      chk("tp_wr_cmd", 256'(qc[i]), 256'(mk(5'h04, 3'd3, 8'd0)));
    for (int k = 0; k < 16; k++) begin
      e = {192'd0, 32'(k), 32'hA5A50000 + 32'(k)};
      chk("tp_rd_data", qd[16 + k], e);
    end

    // Illegal opcode: accepted, no response, no write
    n0 = nresp;
    chk("ill_ready", 256'(req_ready), 256'd1);
    issue(5'h07, 3'd3, 8'd0, 64'h0, 64'h70, {256{1'b1}});
    chk("ill_noresp", 256'(resp_valid), 256'd0);
    cyc(2);
    chk("ill_count", 256'(nresp - n0), 256'd0);
    issue(5'h01, 3'd3, 8'd0, 64'h0, 64'h70, 256'd0);
    chk("ill_mem", resp_data, 256'h00000000A5A50000);
    cyc(1);

    // Reset with a response pending
    resp_ready = 1'b0;
    issue(5'h01, 3'd3, 8'd0, 64'h300, 64'h74, 256'd0);
    chk("mr_valid", 256'(resp_valid), 256'd1);
    nreset = 1'b0;
    #1;
    chk("mr_drop", 256'(resp_valid), 256'd0);
    chk("mr_data", resp_data, 256'd0);
    cyc(2);
    nreset = 1'b1;
    resp_ready = 1'b1;
    cyc(1);
    issue(5'h01, 3'd3, 8'd0, 64'h300, 64'h74, 256'd0);
    chk("mr_mem", resp_data, 256'hCAFE);
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
